run_detect_scheduler: RTL and testbench
=======================================

Name: run_detect_scheduler

Overview:
- Time-multiplexes one run-of-ones detector across N serial bit streams.
- The detector is the same Moore "RUN_LEN consecutive 1s" engine used elsewhere in the design.
- A round-robin arbiter grants one requesting channel per cycle. That channel's bit advances its saved detector state, which is a per-channel saturating run counter.
- Per-channel Moore outputs and a shared hit counter feed downstream control logic.

Parameters:
- N, 4, number of requesting channels (2..8)
- RUN_LEN, 3, consecutive 1s required to assert found (1..15)
- HIT_W, 8, width of the saturating hit counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  N  req[i]=1: channel i presents a bit this cycle
- bit_in  input  N  bit_in[i] is the data bit for channel i; sampled only when granted
- clr  input  N  synchronous per-channel clear of detector state
- grant  output  N  one-hot grant, combinational from req and pointer; all zero when req==0
- found  output  N  registered; found[i]=1 while channel i's run count equals RUN_LEN
- found_any  output  1  OR of found
- hits  output  HIT_W  saturating count of found rising events across all channels

Behaviour:
- Reset (async, immediate on reset=1):
  - run_cnt[i]=0, rr_ptr=0, found=0, found_any=0, hits=0.
  - grant follows req combinationally during reset, but no state updates while reset=1.
- Arbitration:
  - grant[i]=1 for the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N.
  - At most one grant bit is set.
  - On a posedge with any grant, rr_ptr <= (granted index + 1) mod N.
  - With no req, rr_ptr holds.
- Detector update for granted channel g on posedge:
  - bit_in[g]=1: run_cnt[g] <= min(run_cnt[g]+1, RUN_LEN), saturating and holding at RUN_LEN like a terminal state.
  - bit_in[g]=0: run_cnt[g] <= 0.
  - Non-granted channels hold their count. Non-granted bit_in values are ignored, not queued.
- Clear:
  - clr[i]=1 forces run_cnt[i] <= 0 at posedge.
  - clr has priority over a same-cycle grant update for channel i.
  - A cleared channel still consumes its grant; the pointer still advances.
- Outputs (Moore):
  - found[i] <= (next run_cnt[i] == RUN_LEN), registered.
  - Latency: the grant cycle carrying the RUN_LEN-th consecutive 1 is followed by found[i]=1 in the next cycle.
  - found[i] stays high across idle cycles and further 1s. It drops the cycle after a granted 0 or a clr.
- hits:
  - Increments by 1 on a posedge where any found bit goes 0->1.
  - At most one channel can rise per cycle.
  - Saturates at 2^HIT_W-1; it never wraps.
- Widths: run_cnt is $clog2(RUN_LEN+1) bits per channel; rr_ptr is $clog2(N) bits.
- Boundary conditions:
  - RUN_LEN=1: found follows the last granted bit.
  - Reset asserted mid-run: all state zero immediately; the count restarts from 0 after release.
  - All channels requesting every cycle: each channel is granted exactly once per N cycles.

Test Plan:
- Reset release, req=0 for 5 cycles -> grant=0, found=0, hits=0, rr_ptr stays 0.
- Channel 0 only, req[0]=1, bits 1,1,1,1,0 -> found[0] high from cycle 4 through cycle 5, low at cycle 6; hits=1.
- All req=4'b1111, bit_in=4'b1111 for 12 cycles -> grant sequence 0001,0010,0100,1000 repeating. found[i] rises the cycle after the third grant to channel i, one channel per cycle. hits=4.
- Channel 2 at run_cnt=2 gets clr[2]=1 in the same cycle as grant with bit 1 -> run_cnt[2]=0, found[2] stays 0; next grant goes to channel 3.
- Channel 1 at run_cnt=2, reset pulsed asynchronously between edges -> found, hits, rr_ptr=0 immediately. After release, three more granted 1s are needed before found[1]=1.
- HIT_W=2 variant, five separate found rising events -> hits reads 3 and holds at 3.

Source files
------------

// File: rtl/run_detect_scheduler.sv
// Round-robin scheduler sharing one Moore run-of-ones detector across N serial channels.
// Each channel keeps its own saturating run counter; one granted channel advances per cycle.
module run_detect_scheduler #(
  parameter int N       = 4,
  parameter int RUN_LEN = 3,
  parameter int HIT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     bit_in,
  input  logic [N-1:0]     clr,
  output logic [N-1:0]     grant,
  output logic [N-1:0]     found,
  output logic             found_any,
  output logic [HIT_W-1:0] hits
);

  localparam int CW = $clog2(RUN_LEN + 1);
  localparam int PW = $clog2(N);
  localparam logic [CW-1:0] FULL = CW'(RUN_LEN);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] cand;
  logic [PW:0]   sum;
  logic          any_grant;
  logic [CW-1:0] run_cnt  [N];
  logic [CW-1:0] cnt_next [N];
  logic [N-1:0]  found_next;
  logic          hit_rise;

  // Search from the pointer upward, wrapping modulo N; the first requester wins.
  always_comb begin
    grant     = '0;
    gidx      = '0;
    any_grant = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      cand = sum[PW-1:0];
      if (!any_grant && req[cand]) begin
        grant[cand] = 1'b1;
        gidx        = cand;
        any_grant   = 1'b1;
      end
    end
  end

  // Clear beats the grant update, but the grant is still consumed by the pointer.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_next[i] = run_cnt[i];
      if (clr[i]) begin
        cnt_next[i] = '0;
      end else if (grant[i]) begin
        if (!bit_in[i])             cnt_next[i] = '0;
        else if (run_cnt[i] != FULL) cnt_next[i] = run_cnt[i] + 1'b1;
      end
      found_next[i] = (cnt_next[i] == FULL);
    end
    hit_rise = |(found_next & ~found);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      found  <= '0;
      hits   <= '0;
      for (int i = 0; i < N; i++) run_cnt[i] <= '0;
    end else begin
      if (any_grant) rr_ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
      for (int i = 0; i < N; i++) run_cnt[i] <= cnt_next[i];
      found <= found_next;
      if (hit_rise && (hits != '1)) hits <= hits + 1'b1;
    end
  end

  assign found_any = |found;

endmodule

// File: tb/tb_run_detect_scheduler.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
// A second small instance (N=2, RUN_LEN=1, HIT_W=2) covers single-bit runs and hit saturation.
module tb_run_detect_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0, bit_in = '0, clr = '0;
  logic [3:0] grant, found;
  logic       found_any;
  logic [7:0] hits;

  logic [1:0] req2 = '0, bit2 = '0, clr2 = '0;
  logic [1:0] grant2, found2;
  logic       found_any2;
  logic [1:0] hits2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       sel;
    logic [3:0] grant;
    logic [3:0] found;
    logic [7:0] hits;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  run_detect_scheduler #(.N(4), .RUN_LEN(3), .HIT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .clr(clr),
    .grant(grant), .found(found), .found_any(found_any), .hits(hits)
  );

  run_detect_scheduler #(.N(2), .RUN_LEN(1), .HIT_W(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .bit_in(bit2), .clr(clr2),
    .grant(grant2), .found(found2), .found_any(found_any2), .hits(hits2)
  );

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge and queue what the monitor must see mid-cycle.
  task automatic applyStimulus(input string tag, input logic sel, input logic rst,
                               input logic [3:0] r, input logic [3:0] b, input logic [3:0] c,
                               input logic [3:0] eg, input logic [3:0] ef, input logic [7:0] eh);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    if (sel) begin
      req = '0; bit_in = '0; clr = '0;
      req2 = r[1:0]; bit2 = b[1:0]; clr2 = c[1:0];
    end else begin
      req2 = '0; bit2 = '0; clr2 = '0;
      req = r; bit_in = b; clr = c;
    end
    e.tag = tag; e.sel = sel; e.grant = eg; e.found = ef; e.hits = eh;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (!e.sel) begin
        checkOutput({e.tag, ".grant"}, {4'b0, grant}, {4'b0, e.grant});
        checkOutput({e.tag, ".found"}, {4'b0, found}, {4'b0, e.found});
        checkOutput({e.tag, ".found_any"}, {7'b0, found_any}, {7'b0, |e.found});
        checkOutput({e.tag, ".hits"}, hits, e.hits);
      end else begin
        checkOutput({e.tag, ".grant2"}, {6'b0, grant2}, {4'b0, e.grant});
        checkOutput({e.tag, ".found2"}, {6'b0, found2}, {4'b0, e.found});
        checkOutput({e.tag, ".hits2"}, {6'b0, hits2}, e.hits);
      end
    end
  end

  initial begin
    $display("[TB] start");
    // tag, sel, reset, req, bit, clr, exp grant, exp found, exp hits
    applyStimulus("rst_idle", 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    applyStimulus("rst_req0", 0, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 8'd0);
    applyStimulus("rst_req1", 0, 1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 8'd0);
    for (int i = 0; i < 5; i++)
      applyStimulus("idle", 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);

    applyStimulus("ch0_b1", 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 8'd0);
    applyStimulus("ch0_b2", 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 8'd0);
    applyStimulus("ch0_b3", 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 8'd0);
    applyStimulus("ch0_b4", 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 8'd1);
    applyStimulus("ch0_b5", 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'd1);
    applyStimulus("ch0_end", 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd1);
    applyStimulus("ptr_to0", 0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 8'd1);

    applyStimulus("all_c1", 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 8'd1);
    applyStimulus("all_c2", 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 8'd1);
    applyStimulus("all_c3", 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 8'd1);
    applyStimulus("all_c4", 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 8'd1);
    applyStimulus("all_c5", 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 8'd1);
    applyStimulus("all_c6", 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 8'd1);
    applyStimulus("all_c7", 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 8'd1);
    applyStimulus("all_c8", 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 8'd1);
    applyStimulus("all_c9", 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 8'd1);
    applyStimulus("all_c10", 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0010, 4'b0001, 8'd2);
    applyStimulus("all_c11", 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 4'b0011, 8'd3);
    applyStimulus("all_c12", 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b1000, 4'b0111, 8'd4);
    applyStimulus("all_end", 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 8'd5);

    applyStimulus("clr_all", 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 8'd5);
    applyStimulus("ch2_b1", 0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 8'd5);
    applyStimulus("ch2_b2", 0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 8'd5);
    applyStimulus("ch2_clr", 0, 0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 8'd5);
    applyStimulus("after_clr", 0, 0, 4'b1100, 4'b1100, 4'b0000, 4'b1000, 4'b0000, 8'd5);
    applyStimulus("clr_hold", 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd5);
    applyStimulus("ch2_restart", 0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 8'd5);
    applyStimulus("ch2_cnt1", 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd5);

    applyStimulus("ch1_b1", 0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 8'd5);
    applyStimulus("ch1_b2", 0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 8'd5);
    applyStimulus("mid_rst", 0, 1, 4'b1001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 8'd0);
    applyStimulus("post_b1", 0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 8'd0);
    applyStimulus("post_b2", 0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 8'd0);
    applyStimulus("post_b3", 0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 8'd0);
    applyStimulus("post_found", 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 8'd1);

    applyStimulus("r1_h1", 1, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 8'd0);
    applyStimulus("r1_l1", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'd1);
    applyStimulus("r1_h2", 1, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 8'd1);
    applyStimulus("r1_l2", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'd2);
    applyStimulus("r1_h3", 1, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 8'd2);
    applyStimulus("r1_l3", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'd3);
    applyStimulus("r1_h4", 1, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 8'd3);
    applyStimulus("r1_l4", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'd3);
    applyStimulus("r1_h5", 1, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 8'd3);
    applyStimulus("r1_sat", 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 8'd3);
    applyStimulus("r1_ch1", 1, 0, 4'b0011, 4'b0010, 4'b0000, 4'b0010, 4'b0001, 8'd3);
    applyStimulus("r1_both", 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 8'd3);

    @(posedge clk);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
